// File: rtl/frame_axi_waddr_pkg.sv
// Shared definitions for the frame write-address generator: burst size,
// data buffer geometry, FSM state encoding and the burst address helper.
package frame_axi_waddr_pkg;

   // Words per DRAM write burst.
   localparam int unsigned WORD_SIZE  = 64;
   // Data buffer depth in words, with pointer and count widths.
   localparam int unsigned FIFO_DEPTH = 128;
   localparam int unsigned FIFO_AW    = 7;
   localparam int unsigned CNT_W      = 8;

   localparam logic [CNT_W-1:0] FIFO_FULL   = 8'd128;
   localparam logic [31:0]      BURST_WORDS = 32'(WORD_SIZE);
   localparam logic [15:0]      BURST_PEND  = 16'(WORD_SIZE);
   localparam logic [11:0]      X_STEP      = 12'(WORD_SIZE);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_FILL       = 3'd1,
      S_ISSUE_IDLE = 3'd2,
      S_ISSUE      = 3'd3,
      S_ISSUE_WAIT = 3'd4,
      S_DONE       = 3'd5
   } state_t;

   // Byte address of the burst starting at pixel (x, y); wraps modulo 2^32.
   function automatic logic [31:0] burst_addr(input logic [31:0] base,
                                              input logic [11:0] x,
                                              input logic [11:0] y,
                                              input logic [11:0] xsize);
      logic [31:0] line_pix;
      line_pix   = {20'd0, y} * {20'd0, xsize};
      burst_addr = base + ({20'd0, x} << 2) + (line_pix << 2);
   endfunction

endpackage

// File: rtl/frame_wr_fifo.sv
// 32 x 128 first-word-fall-through data buffer with an occupancy count.
// Pushes into a full buffer and pops from an empty one are dropped, so the
// pointers can never overrun or underflow.
module frame_wr_fifo
   import frame_axi_waddr_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0]   mem_r [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_r;
   logic [FIFO_AW-1:0] rd_ptr_r;
   logic [CNT_W-1:0]   count_r;
   logic               push_ok_s;
   logic               pop_ok_s;

   // Qualify push/pop against the current occupancy.
   always_comb begin
      push_ok_s = push && (count_r != FIFO_FULL);
      pop_ok_s  = pop && (count_r != 8'd0);
   end

   // Storage array; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers and occupancy; push and pop together leave the count unchanged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= 7'd0;
         rd_ptr_r <= 7'd0;
         count_r  <= 8'd0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + 7'd1;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + 7'd1;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + 8'd1;
            2'b01:   count_r <= count_r - 8'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   assign dout  = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/frame_axi_waddr.sv
// Frame capture write-address generator. Pixels are buffered in a 128-word
// FIFO; each time 64 uncommanded words are available a 64-word write burst
// is requested at the next raster address of the frame.
// Optional feature: define FRAME_WR_DBUF_EN to alternate the frame base
// between BASE_ADDR and BASE_ADDR + one frame size on every completed frame.
module frame_axi_waddr
   import frame_axi_waddr_pkg::*;
#(
   parameter logic [11:0] X_SIZE    = 12'd256,
   parameter logic [11:0] Y_SIZE    = 12'd256,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic        pix_valid,
   input  logic [31:0] pix_data,
   output logic        pix_ready,
   input  logic        busy,
   output logic        kick,
   output logic [31:0] write_addr,
   output logic [31:0] write_num,
   input  logic        wdata_rd,
   output logic [31:0] wdata,
   output logic        frame_done,
   output logic        sync_err
);

   localparam logic [31:0] TOTAL_PIX   = {20'd0, X_SIZE} * {20'd0, Y_SIZE};
   localparam logic [31:0] FRAME_BYTES = TOTAL_PIX << 2;

   state_t             state_r;
   logic [11:0]        x_cnt_r;
   logic [11:0]        y_cnt_r;
   logic [31:0]        acc_r;
   logic [15:0]        pend_r;
   logic [CNT_W-1:0]   fifo_count_s;
   logic               push_s;
   logic               pop_s;
   logic [CNT_W:0]     count_next_s;
   logic [31:0]        acc_next_s;
   logic [15:0]        pend_next_s;
   logic               idle_next_s;
   logic               ready_next_s;
   logic [31:0]        base_s;

   frame_wr_fifo #(
      .WIDTH (32)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .din   (pix_data),
      .pop   (wdata_rd),
      .dout  (wdata),
      .count (fifo_count_s)
   );

   assign write_num = BURST_WORDS;

`ifdef FRAME_WR_DBUF_EN
   logic bank_r;

   // Frame bank flips once per completed frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bank_r <= 1'b0;
      end else if (state_r == S_DONE) begin
         bank_r <= ~bank_r;
      end else begin
         bank_r <= bank_r;
      end
   end

   // Select the base address of the bank currently being written.
   always_comb begin
      if (bank_r) begin
         base_s = BASE_ADDR + FRAME_BYTES;
      end else begin
         base_s = BASE_ADDR;
      end
   end
`else
   assign base_s = BASE_ADDR;
`endif

   // Next-cycle predictions so pix_ready can be a register yet never overfill.
   always_comb begin
      push_s       = pix_valid && pix_ready;
      pop_s        = wdata_rd && (fifo_count_s != 8'd0);
      count_next_s = {1'b0, fifo_count_s} + {8'd0, push_s} - {8'd0, pop_s};
      if ((state_r == S_IDLE) && frame_start) begin
         acc_next_s  = 32'd0;
         pend_next_s = 16'd0;
      end else if (state_r == S_ISSUE) begin
         acc_next_s  = acc_r + {31'd0, push_s};
         pend_next_s = pend_r + {15'd0, push_s} - BURST_PEND;
      end else begin
         acc_next_s  = acc_r + {31'd0, push_s};
         pend_next_s = pend_r + {15'd0, push_s};
      end
      if (((state_r == S_IDLE) && !frame_start) || (state_r == S_DONE)) begin
         idle_next_s = 1'b1;
      end else begin
         idle_next_s = 1'b0;
      end
      ready_next_s = !idle_next_s && (count_next_s < {1'b0, FIFO_FULL})
                     && (acc_next_s < TOTAL_PIX);
   end

   // Frame FSM with registered kick, address, ready, done and error outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= S_IDLE;
         x_cnt_r    <= 12'd0;
         y_cnt_r    <= 12'd0;
         acc_r      <= 32'd0;
         pend_r     <= 16'd0;
         kick       <= 1'b0;
         write_addr <= 32'd0;
         pix_ready  <= 1'b0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         acc_r      <= acc_next_s;
         pend_r     <= pend_next_s;
         pix_ready  <= ready_next_s;
         frame_done <= 1'b0;
         if (frame_start && (state_r != S_IDLE)) begin
            sync_err <= 1'b1;
         end
         case (state_r)
            S_IDLE: begin
               if (frame_start) begin
                  state_r <= S_FILL;
                  x_cnt_r <= 12'd0;
                  y_cnt_r <= 12'd0;
               end
            end
            S_FILL: begin
               if (pend_r >= BURST_PEND) begin
                  state_r <= S_ISSUE_IDLE;
               end
            end
            S_ISSUE_IDLE: begin
               write_addr <= burst_addr(base_s, x_cnt_r, y_cnt_r, X_SIZE);
               if (!busy) begin
                  state_r <= S_ISSUE;
                  kick    <= 1'b1;
               end
            end
            S_ISSUE: begin
               state_r <= S_ISSUE_WAIT;
               if (x_cnt_r == (X_SIZE - X_STEP)) begin
                  x_cnt_r <= 12'd0;
                  y_cnt_r <= y_cnt_r + 12'd1;
               end else begin
                  x_cnt_r <= x_cnt_r + X_STEP;
               end
            end
            S_ISSUE_WAIT: begin
               if (busy) begin
                  kick <= 1'b0;
                  if (y_cnt_r == Y_SIZE) begin
                     state_r    <= S_DONE;
                     frame_done <= 1'b1;
                  end else begin
                     state_r <= S_FILL;
                  end
               end
            end
            S_DONE: begin
               state_r <= S_IDLE;
            end
            default: begin
               state_r <= S_IDLE;
               kick    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_axi_waddr.sv
// Scoreboard bench for frame_axi_waddr (X_SIZE=256, Y_SIZE=2, BASE_ADDR=0).
// Expected burst addresses are the linear frame offsets base + n*256 bytes,
// expected buffer words are the accepted pixels in arrival order.
module tb_frame_axi_waddr;

   localparam logic [11:0] XS     = 12'd256;
   localparam logic [11:0] YS     = 12'd2;
   localparam logic [31:0] BA     = 32'h0;
   localparam int          TOTAL  = 512;
   localparam logic [31:0] FBYTES = 32'h800;

   logic        clk = 1'b0;
   logic        rst_n, frame_start, pix_valid, busy, wdata_rd;
   logic [31:0] pix_data;
   logic        pix_ready, kick, frame_done, sync_err;
   logic [31:0] write_addr, write_num, wdata;

   frame_axi_waddr #(.X_SIZE(XS), .Y_SIZE(YS), .BASE_ADDR(BA)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .busy(busy), .kick(kick), .write_addr(write_addr), .write_num(write_num),
      .wdata_rd(wdata_rd), .wdata(wdata), .frame_done(frame_done),
      .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model / scoreboard state
   logic [31:0] exp_data[$];
   logic [31:0] exp_addr[$];
   logic [31:0] last_kick_addr;
   int  exp_done = 0, acc_frame = 0, frame_idx = 0, cyc = 0, lat_cyc = 0;
   bit  lat_arm = 0, lat_pending = 0, kick_prev = 0, addr_known = 0;

   // stimulus controls
   bit src_en = 0, src_always = 0, writer_en = 1, force_busy = 0;
   bit rd_block = 0, rd_poke = 0;
   int phase = 0, words_left = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] frame_base(input int idx);
`ifdef FRAME_WR_DBUF_EN
      return (idx % 2 == 1) ? BA + FBYTES : BA;
`else
      return BA + 32'(idx * 0);
`endif
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // monitor: records accepted pixels and compares every DUT output event
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (pix_valid && pix_ready) begin
            exp_data.push_back(pix_data);
            acc_frame++;
            if (acc_frame % 64 == 0) begin
               exp_addr.push_back(frame_base(frame_idx) + 32'((acc_frame / 64 - 1) * 256));
               if (lat_arm && acc_frame == 64) begin
                  lat_pending = 1;
                  lat_cyc     = cyc;
               end
            end
            if (acc_frame == TOTAL) begin
               exp_done++;
               frame_idx++;
            end
         end
         if (kick && !kick_prev) begin
            if (exp_addr.size() == 0) begin
               checks++;
               errors++;
               addr_known = 0;
               $display("FAIL spurious_kick: got kick at addr 0x%08h expected no kick", write_addr);
            end else begin
               last_kick_addr = exp_addr.pop_front();
               addr_known     = 1;
               check("kick_addr", write_addr, last_kick_addr);
               check("write_num", write_num, 32'd64);
            end
            if (lat_pending) begin
               check("kick_latency", 32'(cyc - lat_cyc - 1), 32'd2);
               lat_pending = 0;
            end
         end
         if (!kick && kick_prev && addr_known) begin
            check("addr_stable", write_addr, last_kick_addr);
            addr_known = 0;
         end
         if (wdata_rd && exp_data.size() > 0) begin
            check("wdata", wdata, exp_data.pop_front());
         end
         if (frame_done) begin
            check("frame_done_expected", 32'(exp_done > 0), 32'd1);
            if (exp_done > 0) exp_done--;
         end
      end
      kick_prev = kick;
   end

   // pixel source
   initial begin
      pix_valid = 1'b0;
      pix_data  = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (src_en && acc_frame < TOTAL && (src_always || $urandom_range(0, 3) != 0)) begin
            pix_valid = 1'b1;
            pix_data  = $urandom;
         end else begin
            pix_valid = 1'b0;
         end
      end
   end

   // DRAM writer: busy one cycle after kick, then pops 64 words
   initial begin
      busy     = 1'b0;
      wdata_rd = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         wdata_rd = 1'b0;
         if (!rst_n) begin
            phase      = 0;
            words_left = 0;
         end else begin
            case (phase)
               0: if (kick && writer_en) phase = 1;
               1: begin
                  phase      = 2;
                  words_left = 64;
               end
               default: begin
                  if (words_left == 0) begin
                     phase = 0;
                  end else if (!rd_block && exp_data.size() > 0 && $urandom_range(0, 3) != 0) begin
                     wdata_rd = 1'b1;
                     words_left--;
                  end
               end
            endcase
         end
         busy = (phase == 2) || force_busy;
         if (rd_poke) wdata_rd = 1'b1;
      end
   end

   task automatic start_frame();
      acc_frame   = 0;
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
   endtask

   task automatic wait_acc(input int n, input string name);
      int k = 0;
      while (acc_frame < n && k < 5000) begin
         tick(1);
         k++;
      end
      check({name, "_acc_reached"}, 32'(acc_frame >= n), 32'd1);
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while (!(acc_frame == TOTAL && exp_done == 0 && exp_data.size() == 0 && !busy) && k < 20000) begin
         tick(1);
         k++;
      end
      check({name, "_complete"}, 32'(k < 20000), 32'd1);
   endtask

   initial begin
      int k;
      rst_n       = 1'b0;
      frame_start = 1'b0;
      tick(3);
      check("rst_kick", 32'(kick), 32'd0);
      check("rst_write_addr", write_addr, 32'd0);
      check("rst_write_num", write_num, 32'd64);
      check("rst_pix_ready", 32'(pix_ready), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_sync_err", 32'(sync_err), 32'd0);
      rst_n = 1'b1;
      tick(1);
      src_en = 1;

      // normal frame with latency measurement on the first burst
      lat_arm = 1;
      start_frame();
      wait_done("frame_a");
      lat_arm = 0;
      check("sync_err_clean", 32'(sync_err), 32'd0);

      // writer busy while the first burst waits to issue
      force_busy = 1;
      start_frame();
      wait_acc(64, "frame_b");
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("kick_held_low", 32'(kick), 32'd0);
      end
      force_busy = 0;
      wait_done("frame_b");

      // writer stops popping: buffer fills to 128 and stalls the source
      rd_block   = 1;
      src_always = 1;
      start_frame();
      tick(300);
      check("accepted_when_full", 32'(acc_frame), 32'd128);
      check("pix_ready_full", 32'(pix_ready), 32'd0);
      rd_block   = 0;
      src_always = 0;
      tick(60);
      check("accept_resumes", 32'(acc_frame > 128), 32'd1);
      wait_done("frame_c");

      // spurious frame_start mid frame
      check("sync_err_before", 32'(sync_err), 32'd0);
      start_frame();
      wait_acc(100, "frame_d");
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      tick(1);
      check("sync_err_set", 32'(sync_err), 32'd1);
      wait_done("frame_d");
      check("sync_err_sticky", 32'(sync_err), 32'd1);

      // reset while waiting for the writer to accept a command
      writer_en = 0;
      start_frame();
      k = 0;
      while (!kick && k < 2000) begin
         tick(1);
         k++;
      end
      check("frame_e_kick_seen", 32'(kick), 32'd1);
      tick(2);
      check("kick_hold_wait", 32'(kick), 32'd1);
      src_en = 0;
      tick(1);
      rst_n = 1'b0;
      tick(1);
      check("abort_kick", 32'(kick), 32'd0);
      check("abort_pix_ready", 32'(pix_ready), 32'd0);
      check("abort_write_addr", write_addr, 32'd0);
      check("abort_sync_err", 32'(sync_err), 32'd0);
      exp_data.delete();
      exp_addr.delete();
      exp_done    = 0;
      frame_idx   = 0;
      acc_frame   = 0;
      lat_pending = 0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
      rd_poke = 1;
      tick(3);
      rd_poke = 0;
      tick(2);
      check("no_kick_after_reset", 32'(kick), 32'd0);
      writer_en = 1;
      src_en    = 1;

      // fresh frame after reset: first burst at base, no stale words
      start_frame();
      wait_done("frame_f");

      check("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
      check("done_pending", 32'(exp_done), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/frame_axi_waddr.md
FRAME_AXI_WADDR -- requirements
Module: frame_axi_waddr

Interface
REQ-001 Parameter X_SIZE, default 12'd256, pixels per line; SHALL be a multiple of 64.
REQ-002 Parameter Y_SIZE, default 12'd256, lines per frame.
REQ-003 Parameter BASE_ADDR, default 32'h0, byte address of frame 0.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 frame_start  in  1  one-cycle pulse; starts frame capture.
REQ-007 pix_valid  in  1  source pixel valid.
REQ-008 pix_data  in  32  source pixel, 1 word = 1 pixel.
REQ-009 pix_ready  out  1  pixel accepted when pix_valid && pix_ready.
REQ-010 busy  in  1  DRAM writer busy, same semantics as the read-side address generator.
REQ-011 kick  out  1  write command request.
REQ-012 write_addr  out  32  burst byte address.
REQ-013 write_num  out  32  burst length in words, constant 64.
REQ-014 wdata_rd  in  1  writer pops one word from the data buffer.
REQ-015 wdata  out  32  buffer head word, first-word-fall-through.
REQ-016 frame_done  out  1  one-cycle pulse after the last burst of a frame is accepted.
REQ-017 sync_err  out  1  sticky; set by frame_start outside S_IDLE.

Function
REQ-018 Data buffer SHALL be a 128-word FIFO: push = pix_valid && pix_ready; pop = wdata_rd && count>0; simultaneous push+pop leaves count unchanged.
REQ-019 pix_ready SHALL be 1 only when state != S_IDLE, count<128 and fewer than X_SIZE*Y_SIZE pixels have been accepted this frame.
REQ-020 wdata_rd with count==0 SHALL be ignored and SHALL NOT underflow the pointers.
REQ-021 States: S_IDLE, S_FILL, S_ISSUE_IDLE, S_ISSUE, S_ISSUE_WAIT, S_DONE.
REQ-022 S_IDLE -> S_FILL on frame_start; accepted-pixel, x_cnt and y_cnt cleared.
REQ-023 S_FILL -> S_ISSUE_IDLE when the number of pushed-but-not-yet-commanded words is >= 64.
REQ-024 S_ISSUE_IDLE: write_addr SHALL be registered to BASE_ADDR + x_cnt*4 + y_cnt*X_SIZE*4 (32-bit, wraps modulo 2^32); -> S_ISSUE when busy==0, else stay.
REQ-025 S_ISSUE -> S_ISSUE_WAIT unconditionally; x_cnt += 64; on x_cnt==X_SIZE-64, x_cnt <= 0 and y_cnt += 1.
REQ-026 S_ISSUE_WAIT: hold until busy==1; then -> S_DONE if y_cnt==Y_SIZE, else -> S_FILL.
REQ-027 S_DONE: frame_done=1 for one cycle; -> S_IDLE.
REQ-028 kick SHALL be 1 exactly in S_ISSUE and S_ISSUE_WAIT; write_addr SHALL be stable while kick=1.
REQ-029 frame_start outside S_IDLE SHALL be ignored by the FSM and SHALL set sync_err.
REQ-030 Latency: 64th accepted pixel of a burst to kick rise = 2 cycles with busy==0.

Reset
REQ-031 While rst_n==0 at a clock edge: state S_IDLE, FIFO empty, counters 0, kick 0, write_addr 0, write_num 64, pix_ready 0, frame_done 0, sync_err 0.
REQ-032 Reset mid-burst SHALL abort the frame and discard buffered data; no kick until the next frame_start.

Configuration
REQ-033 Macro FRAME_WR_DBUF_EN defined: base alternates BASE_ADDR / BASE_ADDR+X_SIZE*Y_SIZE*4 per completed frame, starting at BASE_ADDR after reset; toggles at S_DONE.
REQ-034 FRAME_WR_DBUF_EN undefined: base is always BASE_ADDR; no toggle register.

Structure
REQ-035 Shared package SHALL hold WORD_SIZE=64, FIFO depth 128 and the state encodings.
REQ-036 The FIFO SHALL be sub-module frame_wr_fifo (32x128, count output); FSM and address logic in the top level.

Verification (X_SIZE=256, Y_SIZE=2, BASE_ADDR=0)
REQ-037 512 pixels streamed, busy pulses 1 cycle after each kick -> 8 kicks, addrs 0x000,0x100,...,0x700; write_num=64; one frame_done.
REQ-038 busy held 1 for 20 cycles when S_ISSUE_IDLE is entered -> kick stays 0 until busy falls; addr unchanged.
REQ-039 wdata_rd held 0 -> pix_ready falls after 128 pixels; pixel 129 stalled; popping resumes acceptance; wdata order = input order.
REQ-040 frame_start injected at pixel 100 -> sync_err=1, addresses continue from the current frame.
REQ-041 rst_n=0 during S_ISSUE_WAIT -> kick=0 next cycle, FIFO empty; new frame starts at addr 0.
REQ-042 FRAME_WR_DBUF_EN defined, two frames -> frame 2 first addr 0x800.
